// File: rtl/mux8_1_pkg.sv
// Shared constants and types for the registered 8-to-1 bit multiplexer.
// Imported by both the combinational core and the registered top.
package mux8_1_pkg;

    localparam int MUX8_N_IN  = 8;
    localparam int MUX8_SEL_W = 3;

    typedef logic [MUX8_N_IN-1:0]  mux8_data_t;
    typedef logic [MUX8_SEL_W-1:0] mux8_sel_t;

endpackage

// File: rtl/mux8_1_core.sv
// Purely combinational 8:1 bit select, built as a three-level 2:1 tree.
// X or Z on the select or data propagates naturally through the tree.
module mux8_1_core
    import mux8_1_pkg::*;
(
    input  mux8_data_t data_i,
    input  mux8_sel_t  sel_i,
    output logic       bit_o
);

    logic [3:0] level1;
    logic [1:0] level2;

    // Select bit 0 picks within pairs, bit 1 within quads, bit 2 between halves.
    always_comb begin
        level1 = 4'b0;
        level2 = 2'b0;
        bit_o  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            level1[k] = sel_i[0] ? data_i[2*k+1] : data_i[2*k];
        end
        for (int k = 0; k < 2; k++) begin
            level2[k] = sel_i[1] ? level1[2*k+1] : level1[2*k];
        end
        bit_o = sel_i[2] ? level2[1] : level2[0];
    end

endmodule

// File: rtl/mux8_1.sv
// Registered 8-to-1 multiplexer: y is i[s] sampled at the previous rising clk edge.
// Synchronous active-high reset clears the output register.
module mux8_1
    import mux8_1_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  i,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    // The core is hard-wired to 8 inputs, so any other sizing is a build error.
    if (N_IN != MUX8_N_IN || SEL_W != MUX8_SEL_W || N_IN != 2**SEL_W) begin : g_bad_params
        $error("mux8_1: N_IN must be 8 and equal 2**SEL_W");
    end

    logic selBit;
    logic y_d;
    logic y_q;

    mux8_1_core u_core (
        .data_i (i),
        .sel_i  (s),
        .bit_o  (selBit)
    );

    always_comb begin
        y_d = selBit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_mux8_1.sv
// Directed testbench for mux8_1: each task drives its scenario and checks y inline.
// Inputs change on the falling edge; y is sampled 1ns after the rising edge.
module tb_mux8_1;

    logic       clk;
    logic       rst;
    logic [7:0] i;
    logic [2:0] s;
    logic       y;

    int nCompared;
    int nMismatched;

    mux8_1 dut (
        .clk (clk),
        .rst (rst),
        .i   (i),
        .s   (s),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] iv, input logic [2:0] sv, input logic rv);
        @(negedge clk);
        i   = iv;
        s   = sv;
        rst = rv;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            applyStimulus(8'hFF, 3'd7, 1'b1);
            waitEdge();
            nCompared++;
            if (y !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_edge%0d: y=%b expected=%b", n, y, 1'b0);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] patterns [2];
        logic       expected;
        patterns[0] = 8'h01;
        patterns[1] = 8'h80;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(patterns[p], 3'(k), 1'b0);
                waitEdge();
                expected = (p == 0) ? (k == 0) : (k == 7);
                nCompared++;
                if (y !== expected) begin
                    nMismatched++;
                    $display("[TB] FAIL sweep i=%h s=%0d: y=%b expected=%b", patterns[p], k, y, expected);
                end
            end
        end
    endtask

    task automatic test_pattern();
        logic [2:0] sels [5];
        logic       exps [5];
        sels = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd7};
        exps = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'b1010_0101, sels[k], 1'b0);
            waitEdge();
            nCompared++;
            if (y !== exps[k]) begin
                nMismatched++;
                $display("[TB] FAIL pattern s=%0d: y=%b expected=%b", sels[k], y, exps[k]);
            end
        end
    endtask

    task automatic test_latency();
        applyStimulus(8'h01, 3'd0, 1'b0);
        waitEdge();
        nCompared++;
        if (y !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL latency_setup: y=%b expected=%b", y, 1'b1);
        end
        applyStimulus(8'h01, 3'd1, 1'b0);
        #1;
        nCompared++;
        if (y !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL latency_hold: y=%b expected=%b", y, 1'b1);
        end
        waitEdge();
        nCompared++;
        if (y !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL latency_update: y=%b expected=%b", y, 1'b0);
        end
    endtask

    task automatic test_reset_midstream();
        applyStimulus(8'hFF, 3'd3, 1'b0);
        waitEdge();
        nCompared++;
        if (y !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_before: y=%b expected=%b", y, 1'b1);
        end
        applyStimulus(8'hFF, 3'd3, 1'b1);
        waitEdge();
        nCompared++;
        if (y !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_asserted: y=%b expected=%b", y, 1'b0);
        end
        applyStimulus(8'hFF, 3'd3, 1'b0);
        waitEdge();
        nCompared++;
        if (y !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_released: y=%b expected=%b", y, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0] iv;
        logic [2:0] sv;
        logic       expected;
        for (int n = 0; n < 16; n++) begin
            iv = 8'($urandom_range(0, 255));
            sv = 3'($urandom_range(0, 7));
            expected = iv[sv];
            applyStimulus(iv, sv, 1'b0);
            waitEdge();
            nCompared++;
            if (y !== expected) begin
                nMismatched++;
                $display("[TB] FAIL random%0d i=%h s=%0d: y=%b expected=%b", n, iv, sv, y, expected);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst = 1'b1;
        i   = 8'h00;
        s   = 3'd0;
        test_reset();
        test_sweep();
        test_pattern();
        test_latency();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
